// File: rtl/paint_pkg.sv
// Shared encodings between the paint controller and the rectangle draw datapath.
// ALU select codes, draw FSM states and default screen geometry.
package paint_pkg;

   localparam logic [1:0] ALU_IDLE    = 2'b00;
   localparam logic [1:0] ALU_RECT    = 2'b01;
   localparam logic [1:0] ALU_OUTLINE = 2'b10;
   localparam logic [1:0] ALU_FREE    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SWEEP = 2'd2,
      ST_HOLD  = 2'd3
   } draw_state_t;

   localparam int DEF_X_W   = 8;
   localparam int DEF_Y_W   = 7;
   localparam int DEF_C_W   = 3;
   localparam int DEF_X_MAX = 160;
   localparam int DEF_Y_MAX = 120;

endpackage

// File: rtl/raster_counter.sv
// Raster walker over a latched box, x inner; start latches bounds, step advances one pixel.
// Zero-latency last/on_edge flags from the current position; step is ignored on the last pixel.
module raster_counter #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           Clock,
   input  logic           reset_N,
   input  logic           start,
   input  logic           step,
   input  logic [X_W-1:0] x_lo,
   input  logic [X_W-1:0] x_hi,
   input  logic [Y_W-1:0] y_lo,
   input  logic [Y_W-1:0] y_hi,
   output logic [X_W-1:0] cx,
   output logic [Y_W-1:0] cy,
   output logic           last,
   output logic           on_edge
);

   logic [X_W-1:0] xmin_q, xmax_q;
   logic [Y_W-1:0] ymin_q, ymax_q;

   always_ff @(posedge Clock or negedge reset_N) begin
      if (!reset_N) begin
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         cx     <= '0;
         cy     <= '0;
      end else if (start) begin
         xmin_q <= x_lo;
         xmax_q <= x_hi;
         ymin_q <= y_lo;
         ymax_q <= y_hi;
         cx     <= x_lo;
         cy     <= y_lo;
      end else if (step && !last) begin
         if (cx == xmax_q) begin
            cx <= xmin_q;
            cy <= cy + 1'b1;
         end else begin
            cx <= cx + 1'b1;
         end
      end
   end

   assign last    = (cx == xmax_q) && (cy == ymax_q);
   assign on_edge = (cx == xmin_q) || (cx == xmax_q) || (cy == ymin_q) || (cy == ymax_q);

endmodule

// File: rtl/rect_draw_datapath.sv
// Paint datapath: clamped corner/colour registers, filled/outline rectangle raster, freeform plot.
// First rect pixel two cycles after enable; abort when enable drops. Outline mode needs OUTLINE_EN.
module rect_draw_datapath
   import paint_pkg::*;
#(
   parameter int X_W   = DEF_X_W,
   parameter int Y_W   = DEF_Y_W,
   parameter int C_W   = DEF_C_W,
   parameter int X_MAX = DEF_X_MAX,
   parameter int Y_MAX = DEF_Y_MAX
) (
   input  logic           Clock,
   input  logic           reset_N,
   input  logic [X_W-1:0] data_in,
   input  logic [C_W-1:0] colour_in,
   input  logic           loadX,
   input  logic           loadY,
   input  logic           loadX2,
   input  logic           loadY2,
   input  logic           loadC,
   input  logic           enable,
   input  logic [1:0]     alu_select,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [C_W-1:0] colour_out,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   localparam logic [X_W-1:0] X_LIM   = X_W'(X_MAX - 1);
   localparam logic [X_W-1:0] Y_LIM_X = X_W'(Y_MAX - 1);
   localparam logic [Y_W-1:0] Y_LIM   = Y_W'(Y_MAX - 1);

   logic [X_W-1:0] x1_q, x2_q, x_clamp, x_lo, x_hi, cx;
   logic [Y_W-1:0] y1_q, y2_q, y_clamp, y_lo, y_hi, cy;
   logic [C_W-1:0] colour_q;
   draw_state_t    state;
   logic           outline_q, start_ok, outline_sel, last, on_edge;

   // Compare y against the full switch value so large entries clamp rather than alias.
   assign x_clamp = (data_in > X_LIM)   ? X_LIM : data_in;
   assign y_clamp = (data_in > Y_LIM_X) ? Y_LIM : data_in[Y_W-1:0];

   always_ff @(posedge Clock or negedge reset_N) begin
      if (!reset_N) begin
         x1_q     <= '0;
         y1_q     <= '0;
         x2_q     <= '0;
         y2_q     <= '0;
         colour_q <= '0;
      end else begin
         if (loadX)  x1_q     <= x_clamp;
         if (loadY)  y1_q     <= y_clamp;
         if (loadX2) x2_q     <= x_clamp;
         if (loadY2) y2_q     <= y_clamp;
         if (loadC)  colour_q <= colour_in;
      end
   end

   assign x_lo = (x1_q <= x2_q) ? x1_q : x2_q;
   assign x_hi = (x1_q <= x2_q) ? x2_q : x1_q;
   assign y_lo = (y1_q <= y2_q) ? y1_q : y2_q;
   assign y_hi = (y1_q <= y2_q) ? y2_q : y1_q;

   always_comb begin
      start_ok    = 1'b0;
      outline_sel = 1'b0;
      case (alu_select)
         ALU_RECT: start_ok = 1'b1;
`ifdef OUTLINE_EN
         ALU_OUTLINE: begin
            start_ok    = 1'b1;
            outline_sel = 1'b1;
         end
`endif
         ALU_IDLE, ALU_FREE: start_ok = 1'b0;
         default: start_ok = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge reset_N) begin
      if (!reset_N) begin
         state     <= ST_IDLE;
         outline_q <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && start_ok) begin
                  state     <= ST_SETUP;
                  outline_q <= outline_sel;
               end
            end
            ST_SETUP: state <= enable ? ST_SWEEP : ST_IDLE;
            ST_SWEEP: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (last) begin
                  state <= ST_HOLD;
                  done  <= 1'b1;
               end
            end
            ST_HOLD: if (!enable) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_raster (
      .Clock   (Clock),
      .reset_N (reset_N),
      .start   (state == ST_SETUP),
      .step    ((state == ST_SWEEP) && enable),
      .x_lo    (x_lo),
      .x_hi    (x_hi),
      .y_lo    (y_lo),
      .y_hi    (y_hi),
      .cx      (cx),
      .cy      (cy),
      .last    (last),
      .on_edge (on_edge)
   );

   always_comb begin
      plot  = 1'b0;
      x_out = x1_q;
      y_out = y1_q;
      case (state)
         ST_IDLE: plot = enable && (alu_select == ALU_FREE);
         ST_SWEEP: begin
            plot  = enable && (!outline_q || on_edge);
            x_out = cx;
            y_out = cy;
         end
         default: plot = 1'b0;
      endcase
   end

   assign busy       = (state == ST_SETUP) || (state == ST_SWEEP);
   assign colour_out = colour_q;

endmodule

// File: tb/tb_rect_draw_datapath.sv
// Directed bench for rect_draw_datapath; inputs driven and outputs sampled on the falling edge.
module tb_rect_draw_datapath;
   import paint_pkg::*;

   logic       Clock = 1'b0;
   logic       reset_N = 1'b0;
   logic [7:0] data_in = '0;
   logic [2:0] colour_in = 3'd5;
   logic       loadX = 0, loadY = 0, loadX2 = 0, loadY2 = 0, loadC = 1'b1;
   logic       enable = 0;
   logic [1:0] alu_select = ALU_IDLE;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot, busy, done;

   int errors = 0;
   int checks = 0;
   int cap_x[64], cap_y[64], cap_c[64];
   int n_plot, n_done, first_idx, done_idx;

   rect_draw_datapath dut (
      .Clock(Clock), .reset_N(reset_N), .data_in(data_in), .colour_in(colour_in),
      .loadX(loadX), .loadY(loadY), .loadX2(loadX2), .loadY2(loadY2), .loadC(loadC),
      .enable(enable), .alu_select(alu_select), .x_out(x_out), .y_out(y_out),
      .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
   );

   always #5 Clock = ~Clock;

   task automatic load_corners(input logic [7:0] x1, y1, x2, y2);
      @(negedge Clock); data_in = x1; loadX = 1'b1;
      @(negedge Clock); loadX = 1'b0; data_in = y1; loadY = 1'b1;
      @(negedge Clock); loadY = 1'b0; data_in = x2; loadX2 = 1'b1;
      @(negedge Clock); loadX2 = 1'b0; data_in = y2; loadY2 = 1'b1;
      @(negedge Clock); loadY2 = 1'b0;
   endtask

   task automatic run_capture(input int cycles);
      n_plot = 0; n_done = 0; first_idx = -1; done_idx = -1;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge Clock);
         if (plot === 1'b1) begin
            if (n_plot < 64) begin
               cap_x[n_plot] = int'(x_out);
               cap_y[n_plot] = int'(y_out);
               cap_c[n_plot] = int'(colour_out);
            end
            if (n_plot == 0) first_idx = i;
            n_plot++;
         end
         if (done === 1'b1) begin
            n_done++;
            done_idx = i;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (x_out !== 8'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", x_out); end
      checks++; if (y_out !== 7'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_out); end
      checks++; if (colour_out !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d want 0", colour_out); end
      checks++; if ({plot, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {plot, busy, done}); end
      @(negedge Clock); reset_N = 1'b1;
   endtask

   task automatic check_six(input string name, input int colour);
      int ex[6] = '{5, 6, 7, 5, 6, 7};
      int ey[6] = '{3, 3, 3, 4, 4, 4};
      checks++; if (n_plot != 6) begin errors++; $display("FAIL %s_count: got %0d want 6", name, n_plot); end
      checks++; if (first_idx != 2) begin errors++; $display("FAIL %s_latency: got %0d want 2", name, first_idx); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (cap_x[k] != ex[k] || cap_y[k] != ey[k]) begin
            errors++;
            $display("FAIL %s_pix%0d: got (%0d,%0d) want (%0d,%0d)", name, k, cap_x[k], cap_y[k], ex[k], ey[k]);
         end
      end
      checks++; if (n_done != 1 || done_idx != 8) begin errors++; $display("FAIL %s_done: got %0d pulses at %0d want 1 at 8", name, n_done, done_idx); end
      checks++; if (cap_c[0] != colour) begin errors++; $display("FAIL %s_colour: got %0d want %0d", name, cap_c[0], colour); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_hold_busy: got %b want 0", name, busy); end
   endtask

   task automatic test_filled_rect;
      load_corners(8'd5, 8'd3, 8'd7, 8'd4);
      @(negedge Clock); alu_select = ALU_RECT; enable = 1'b1;
      run_capture(12);
      check_six("rect", 5);
      enable = 1'b0;
   endtask

   task automatic test_back_to_back;
      colour_in = 3'd6;
      load_corners(8'd7, 8'd4, 8'd5, 8'd3);
      @(negedge Clock); alu_select = ALU_RECT; enable = 1'b1;
      run_capture(12);
      check_six("swapped", 6);
      enable = 1'b0;
   endtask

   task automatic test_clamp;
      load_corners(8'd200, 8'd130, 8'd200, 8'd130);
      @(negedge Clock); alu_select = ALU_RECT; enable = 1'b1;
      run_capture(10);
      checks++; if (n_plot != 1) begin errors++; $display("FAIL clamp_count: got %0d want 1", n_plot); end
      checks++; if (cap_x[0] != 159 || cap_y[0] != 119) begin errors++; $display("FAIL clamp_pix: got (%0d,%0d) want (159,119)", cap_x[0], cap_y[0]); end
      checks++; if (n_done != 1 || done_idx != 3) begin errors++; $display("FAIL clamp_done: got %0d pulses at %0d want 1 at 3", n_done, done_idx); end
      enable = 1'b0;
   endtask

   task automatic test_freeform;
      @(negedge Clock); data_in = 8'd20; loadY = 1'b1;
      @(negedge Clock); loadY = 1'b0; alu_select = ALU_FREE; enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_in = 8'(10 + k); loadX = 1'b1;
         @(negedge Clock);
         checks++;
         if (plot !== 1'b1 || int'(x_out) != 10 + k || y_out !== 7'd20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL free_step%0d: got plot=%b (%0d,%0d) busy=%b want plot=1 (%0d,20) busy=0", k, plot, x_out, y_out, busy, 10 + k);
         end
      end
      loadX = 1'b0; enable = 1'b0;
      #1;
      checks++; if (plot !== 1'b0) begin errors++; $display("FAIL free_off: got plot=%b want 0", plot); end
   endtask

   task automatic test_abort;
      int plots = 0, dones = 0;
      load_corners(8'd0, 8'd0, 8'd9, 8'd0);
      @(negedge Clock); alu_select = ALU_RECT; enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge Clock);
         if (plot === 1'b1) plots++;
      end
      enable = 1'b0;
      #1;
      checks++; if (plot !== 1'b0) begin errors++; $display("FAIL abort_plot_now: got %b want 0", plot); end
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (plot === 1'b1) plots++;
         if (done === 1'b1) dones++;
      end
      checks++; if (plots != 2) begin errors++; $display("FAIL abort_count: got %0d want 2", plots); end
      checks++; if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", dones); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
   endtask

   task automatic test_outline;
      load_corners(8'd20, 8'd30, 8'd23, 8'd33);
      @(negedge Clock); alu_select = ALU_OUTLINE; enable = 1'b1;
      run_capture(22);
`ifdef OUTLINE_EN
      checks++; if (n_plot != 12) begin errors++; $display("FAIL outline_count: got %0d want 12", n_plot); end
      checks++; if (cap_x[0] != 20 || cap_y[0] != 30 || cap_x[11] != 23 || cap_y[11] != 33) begin
         errors++; $display("FAIL outline_ends: got (%0d,%0d)..(%0d,%0d) want (20,30)..(23,33)", cap_x[0], cap_y[0], cap_x[11], cap_y[11]);
      end
      checks++; if (n_done != 1 || done_idx != 18) begin errors++; $display("FAIL outline_done: got %0d pulses at %0d want 1 at 18", n_done, done_idx); end
`else
      checks++; if (n_plot != 0) begin errors++; $display("FAIL outline_off_count: got %0d want 0", n_plot); end
      checks++; if (n_done != 0) begin errors++; $display("FAIL outline_off_done: got %0d want 0", n_done); end
`endif
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_sweep;
      load_corners(8'd1, 8'd1, 8'd8, 8'd8);
      @(negedge Clock); alu_select = ALU_RECT; enable = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      checks++; if (plot !== 1'b1 || x_out !== 8'd1) begin errors++; $display("FAIL rst_pre: got plot=%b x=%0d want plot=1 x=1", plot, x_out); end
      #2 reset_N = 1'b0;
      #1;
      checks++; if (plot !== 1'b0 || x_out !== 8'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_async: got plot=%b x=%0d busy=%b want 0 0 0", plot, x_out, busy);
      end
      enable = 1'b0;
      @(negedge Clock); reset_N = 1'b1;
      @(negedge Clock);
      checks++; if (busy !== 1'b0 || plot !== 1'b0 || y_out !== 7'd0) begin
         errors++; $display("FAIL rst_idle: got busy=%b plot=%b y=%0d want 0 0 0", busy, plot, y_out);
      end
   endtask

   initial begin
      test_reset;
      test_filled_rect;
      test_back_to_back;
      test_clamp;
      test_freeform;
      test_abort;
      test_outline;
      test_reset_mid_sweep;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
